// File: rtl/prog_counter_bank.sv
// Bank of independent up/down counters with per-channel compare registers,
// one-cycle match pulses and sticky terminal-count flags.
module prog_counter_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] load,
  input  logic [CHANNELS-1:0] enable,
  input  logic [CHANNELS-1:0] dir,
  input  logic                sat_mode,
  input  logic [WIDTH-1:0]    load_value,
  input  logic [CHANNELS-1:0] cmp_we,
  input  logic [CHANNELS-1:0] tc_clr,
  input  logic [SEL_W-1:0]    rd_sel,
  input  logic                rd_oe,
  output logic [WIDTH-1:0]    rd_data,
  output logic [CHANNELS-1:0] match,
  output logic [CHANNELS-1:0] tc_flag
);

  localparam logic [WIDTH-1:0] MAX_V = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0] cmp_q, cmp_d;
  logic [CHANNELS-1:0]            match_q, match_d;
  logic [CHANNELS-1:0]            tc_q, tc_d;
  logic [CHANNELS-1:0]            step, at_limit, terminal, written;

  always_comb begin
    cnt_d    = cnt_q;
    cmp_d    = cmp_q;
    match_d  = '0;
    tc_d     = tc_q;
    step     = '0;
    at_limit = '0;
    terminal = '0;
    written  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      step[i]     = enable[i] & ~load[i];
      at_limit[i] = dir[i] ? (cnt_q[i] == MAX_V) : (cnt_q[i] == '0);
      // A terminal event is the same in both modes; only the next value differs.
      terminal[i] = step[i] & at_limit[i];
      written[i]  = load[i] | enable[i];

      if (load[i]) begin
        cnt_d[i] = load_value;
      end else if (enable[i]) begin
        if (sat_mode && at_limit[i]) begin
          cnt_d[i] = cnt_q[i];
        end else if (dir[i]) begin
          cnt_d[i] = cnt_q[i] + ONE_V;
        end else begin
          cnt_d[i] = cnt_q[i] - ONE_V;
        end
      end

      // Compare against the old cmp value even when it is being rewritten.
      match_d[i] = written[i] & (cnt_d[i] == cmp_q[i]);

      if (cmp_we[i]) begin
        cmp_d[i] = load_value;
      end

      tc_d[i] = terminal[i] | (tc_q[i] & ~tc_clr[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      cmp_q   <= {CHANNELS{MAX_V}};
      match_q <= '0;
      tc_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_oe) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (int'(rd_sel) == i) begin
          rd_data = cnt_q[i];
        end
      end
    end
  end

  assign match   = match_q;
  assign tc_flag = tc_q;

endmodule

// File: tb/tb_prog_counter_bank.sv
// Vector-table bench for prog_counter_bank (WIDTH=8, CHANNELS=4) with a
// scoreboard queue of expected {rd_data, match, tc_flag} after each edge.
module tb_prog_counter_bank;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] load, enable, dir, cmp_we, tc_clr;
  logic          sat_mode;
  logic [W-1:0]  load_value;
  logic [SW-1:0] rd_sel;
  logic          rd_oe;
  logic [W-1:0]  rd_data;
  logic [CH-1:0] match, tc_flag;

  prog_counter_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .enable     (enable),
    .dir        (dir),
    .sat_mode   (sat_mode),
    .load_value (load_value),
    .cmp_we     (cmp_we),
    .tc_clr     (tc_clr),
    .rd_sel     (rd_sel),
    .rd_oe      (rd_oe),
    .rd_data    (rd_data),
    .match      (match),
    .tc_flag    (tc_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [CH-1:0] load, en, dir;
    logic          sat;
    logic [W-1:0]  val;
    logic [CH-1:0] cmp_we, tc_clr;
    logic [SW-1:0] sel;
    logic [W-1:0]  exp_rd;
    logic [CH-1:0] exp_match, exp_tc;
  } vec_t;

  vec_t          vq[$];
  logic [15:0]   exp_q[$];
  string         name_q[$];
  int            checks = 0;
  int            errors = 0;

  function automatic vec_t mk(string nm, logic [3:0] ld, logic [3:0] en, logic [3:0] dr,
                              logic sat, logic [7:0] val, logic [3:0] cwe, logic [3:0] clr,
                              logic [1:0] sel, logic [7:0] rd, logic [3:0] m, logic [3:0] tc);
    vec_t v;
    v.name = nm; v.load = ld; v.en = en; v.dir = dr; v.sat = sat; v.val = val;
    v.cmp_we = cwe; v.tc_clr = clr; v.sel = sel;
    v.exp_rd = rd; v.exp_match = m; v.exp_tc = tc;
    return v;
  endfunction

  task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    load = '0; enable = '0; dir = '0; sat_mode = 1'b0; load_value = '0;
    cmp_we = '0; tc_clr = '0;
  endtask

  // Drive one vector, record its expectation, then compare after the edge.
  task automatic drive(vec_t v);
    logic [15:0] e;
    string       nm;
    load = v.load; enable = v.en; dir = v.dir; sat_mode = v.sat;
    load_value = v.val; cmp_we = v.cmp_we; tc_clr = v.tc_clr;
    rd_sel = v.sel; rd_oe = 1'b1;
    exp_q.push_back({v.exp_rd, v.exp_match, v.exp_tc});
    name_q.push_back(v.name);
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    check({nm, "_rd"},    rd_data,        e[15:8]);
    check({nm, "_match"}, 8'(match),      8'(e[7:4]));
    check({nm, "_tc"},    8'(tc_flag),    8'(e[3:0]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    //      name            ld en dr sat val  cwe clr sel  rd   m  tc
    vq.push_back(mk("ld0_fd",      1, 0, 0, 0, 8'hFD, 0, 0, 0, 8'hFD, 0, 0));
    vq.push_back(mk("wrap_fe",     0, 1, 1, 0, 8'h00, 0, 0, 0, 8'hFE, 0, 0));
    vq.push_back(mk("wrap_ff",     0, 1, 1, 0, 8'h00, 0, 0, 0, 8'hFF, 1, 0));
    vq.push_back(mk("wrap_00",     0, 1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1));
    vq.push_back(mk("wrap_01",     0, 1, 1, 0, 8'h00, 0, 0, 0, 8'h01, 0, 1));
    vq.push_back(mk("sat_ld",      1, 0, 1, 1, 8'hFD, 0, 1, 0, 8'hFD, 0, 0));
    vq.push_back(mk("sat_fe",      0, 1, 1, 1, 8'h00, 0, 0, 0, 8'hFE, 0, 0));
    vq.push_back(mk("sat_ff",      0, 1, 1, 1, 8'h00, 0, 0, 0, 8'hFF, 1, 0));
    vq.push_back(mk("sat_hold1",   0, 1, 1, 1, 8'h00, 0, 0, 0, 8'hFF, 1, 1));
    vq.push_back(mk("sat_hold2",   0, 1, 1, 1, 8'h00, 0, 0, 0, 8'hFF, 1, 1));
    vq.push_back(mk("cmp2_we",     0, 0, 0, 0, 8'h05, 4, 0, 2, 8'h00, 0, 1));
    vq.push_back(mk("ld2_03",      4, 0, 0, 0, 8'h03, 0, 0, 2, 8'h03, 0, 1));
    vq.push_back(mk("up2_04",      0, 4, 4, 0, 8'h00, 0, 0, 2, 8'h04, 0, 1));
    vq.push_back(mk("up2_05",      0, 4, 4, 0, 8'h00, 0, 0, 2, 8'h05, 4, 1));
    vq.push_back(mk("up2_06",      0, 4, 4, 0, 8'h00, 0, 0, 2, 8'h06, 0, 1));
    vq.push_back(mk("up2_07",      0, 4, 4, 0, 8'h00, 0, 0, 2, 8'h07, 0, 1));
    vq.push_back(mk("ld_en1",      2, 2, 2, 0, 8'h10, 0, 0, 1, 8'h10, 0, 1));
    vq.push_back(mk("hold1",       0, 0, 0, 0, 8'h00, 0, 0, 1, 8'h10, 0, 1));
    vq.push_back(mk("tc3_setwins", 0, 8, 0, 0, 8'h00, 0, 8, 3, 8'hFF, 8, 9));
    vq.push_back(mk("tc3_clr",     0, 0, 0, 0, 8'h00, 0, 8, 3, 8'hFF, 0, 1));
    vq.push_back(mk("down3_fe",    0, 8, 0, 1, 8'h00, 0, 0, 3, 8'hFE, 0, 1));
    vq.push_back(mk("ld3_00",      8, 0, 0, 0, 8'h00, 0, 0, 3, 8'h00, 0, 1));
    vq.push_back(mk("sat3_hold0",  0, 8, 0, 1, 8'h00, 0, 0, 3, 8'h00, 0, 9));
    vq.push_back(mk("ld_cmp2",     4, 0, 0, 0, 8'h20, 4, 0, 2, 8'h20, 0, 9));
    vq.push_back(mk("down2_1f",    0, 4, 0, 0, 8'h00, 0, 0, 2, 8'h1F, 0, 9));
    vq.push_back(mk("ld2_20",      4, 0, 0, 0, 8'h20, 0, 0, 2, 8'h20, 4, 9));

    // Reset is asynchronous: outputs must be clear before any clock edge.
    rst = 1'b1;
    clear_inputs();
    rd_sel = '0;
    rd_oe  = 1'b1;
    #2;
    check("rst_rd",    rd_data,       8'h00);
    check("rst_match", 8'(match),     8'h00);
    check("rst_tc",    8'(tc_flag),   8'h00);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    foreach (vq[k]) drive(vq[k]);

    // Mid-count asynchronous reset, between edges, with all channels enabled.
    enable = 4'hF; dir = 4'hF; load = '0; cmp_we = '0; tc_clr = '0;
    rd_sel = 2'd2;
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_rd",    rd_data,     8'h00);
    check("async_rst_match", 8'(match),   8'h00);
    check("async_rst_tc",    8'(tc_flag), 8'h00);
    #1;
    rst = 1'b0;
    clear_inputs();

    // cmp2 was 0x20; a match on 0xFF proves it returned to its reset value.
    drive(mk("post_rst_ld2", 4, 0, 0, 0, 8'hFF, 0, 0, 2, 8'hFF, 4, 0));
    clear_inputs();

    rd_sel = 2'd2;
    rd_oe  = 1'b0;
    #1;
    check("rd_oe_off", rd_data, 8'h00);
    rd_oe  = 1'b1;
    rd_sel = 2'd0;
    #1;
    check("rd_sel0", rd_data, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
